// File: rtl/data_memory_sized.sv
// data_memory_sized
//   Byte-addressed, little-endian data memory for the MIPS MEM stage.
//   Supports byte/half/word loads and stores with optional sign extension
//   on narrow loads, programmable wait states, and error reporting for
//   misaligned, out-of-range or illegal-size requests. One request is
//   outstanding at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            sign-extend narrow loads
//   req_addr              byte address
//   req_wdata             right-justified store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load result (0 for stores and errors)
//   rsp_error             request was rejected, no memory side effect
//   fsm_state             debug view of the control FSM (0 IDLE, 1 BUSY, 2 RESP)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE; rsp_valid is high only in RESP,
// and rsp_rdata/rsp_error stay stable until the response is taken. Inputs
// that are not part of an active transfer are ignored.

module data_memory_sized #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0,
  parameter int INIT_BYTES  = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [1:0]  fsm_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]  cnt;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Power-up image: byte i holds i for the first INIT_BYTES bytes. This is
  // a load-time image only; reset never touches the storage.
  function automatic logic [DEPTH*8-1:0] init_image();
    logic [DEPTH*8-1:0] img;
    img = '0;
    for (int i = 0; i < INIT_BYTES && i < DEPTH; i++) begin
      img[i*8 +: 8] = 8'(i);
    end
    return img;
  endfunction

  logic [DEPTH*8-1:0] mem = init_image();

  // ---------------------------------------------------------------------
  // Access decode on the latched request
  // ---------------------------------------------------------------------
  logic                  access;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  err;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0]            rb0, rb1, rb2, rb3;
  logic [31:0]           load_data;

  assign access = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    misaligned = 1'b0;
    case (size_q)
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = |addr_q[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Any set bit above the used address field means the address is >= DEPTH.
  assign out_of_range = |addr_q[31:ADDR_WIDTH];
  assign err          = misaligned || out_of_range || (size_q == 2'b11);

  // Byte lanes wrap inside the array; the wrapped lanes are only ever used
  // by requests that the error checks already reject.
  assign a0 = addr_q[ADDR_WIDTH-1:0];
  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);

  assign rb0 = mem[{a0, 3'b000} +: 8];
  assign rb1 = mem[{a1, 3'b000} +: 8];
  assign rb2 = mem[{a2, 3'b000} +: 8];
  assign rb3 = mem[{a3, 3'b000} +: 8];

  always_comb begin
    load_data = 32'd0;
    if (!err && !write_q) begin
      case (size_q)
        2'b00:   load_data = {{24{signed_q & rb0[7]}}, rb0};
        2'b01:   load_data = {{16{signed_q & rb1[7]}}, rb1, rb0};
        2'b10:   load_data = {rb3, rb2, rb1, rb0};
        default: load_data = 32'd0;
      endcase
    end
  end

  // Storage write port. No reset: contents survive rst_n, and a request
  // discarded by reset never reaches BUSY with cnt==0 so it never writes.
  always_ff @(posedge clk) begin
    if (access && write_q && !err) begin
      mem[{a0, 3'b000} +: 8] <= wdata_q[7:0];
      if (size_q != 2'b00) begin
        mem[{a1, 3'b000} +: 8] <= wdata_q[15:8];
      end
      if (size_q == 2'b10) begin
        mem[{a2, 3'b000} +: 8] <= wdata_q[23:16];
        mem[{a3, 3'b000} +: 8] <= wdata_q[31:24];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = BUSY;
      BUSY:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    fsm_state = state;
  end

  // ---------------------------------------------------------------------
  // Request latch, wait counter and response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      write_q   <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            cnt      <= 4'(WAIT_STATES);
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_rdata <= load_data;
            rsp_error <= err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
